// File: rtl/board_painter.sv
// Four-stage pixel painter for the battleship screen: banners, N tile boards,
// icon lookup with colour-key transparency and a blinking cursor outline.
module board_painter #(
  parameter int          GRID         = 10,
  parameter int          TILE_LOG2    = 5,
  parameter int          BOARDS       = 2,
  parameter int          TOP_H        = 100,
  parameter int          TILE_W       = 4,
  parameter int          TADDR_W      = 8,
  parameter int          BLINK_LOG2   = 5,
  parameter logic [11:0] TOP_COLOR    = 12'hFFF,
  parameter logic [11:0] BOTTOM_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h00F,
  parameter logic [11:0] CURSOR_COLOR = 12'hF00,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F,
  localparam int BW = (BOARDS > 1) ? $clog2(BOARDS) : 1,
  localparam int GW = (GRID > 1) ? $clog2(GRID) : 1,
  localparam int IW = TILE_W + 2 * TILE_LOG2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               vid_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               frame_tick,
  input  logic               cursor_en,
  input  logic [BW-1:0]      cursor_board,
  input  logic [GW-1:0]      cursor_row,
  input  logic [GW-1:0]      cursor_col,
  output logic [TADDR_W-1:0] tile_address,
  input  logic [TILE_W-1:0]  tile_data,
  output logic [IW-1:0]      icon_address,
  input  logic [11:0]        icon_data,
  output logic [11:0]        screen_color,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               vid_on_out
);

  localparam int TILE     = 1 << TILE_LOG2;
  localparam int BRD_W    = GRID * TILE;
  localparam int BOARD_Y1 = TOP_H + BRD_W;

  localparam logic [15:0] TOP16   = 16'(TOP_H);
  localparam logic [15:0] Y1_16   = 16'(BOARD_Y1);
  localparam logic [15:0] XE16    = 16'(BOARDS * BRD_W);
  localparam logic [15:0] BRDW16  = 16'(BRD_W);
  localparam logic [15:0] GRID16  = 16'(GRID);
  localparam logic [15:0] GG16    = 16'(GRID * GRID);

  localparam logic [TILE_LOG2-1:0] P_LO = TILE_LOG2'(1);
  localparam logic [TILE_LOG2-1:0] P_HI = TILE_LOG2'(TILE - 2);

  typedef enum logic [1:0] {
    R_OUT, R_TOP, R_BOARD, R_BOT
  } region_t;

  typedef struct packed {
    region_t              region;
    logic                 hit;
    logic [TILE_LOG2-1:0] px;
    logic [TILE_LOG2-1:0] py;
    logic                 vid;
    logic                 hs;
    logic                 vs;
  } pipe_t;

  localparam pipe_t RST_P = '{
    region: R_OUT, hit: 1'b0, px: '0, py: '0,
    vid: 1'b0, hs: 1'b1, vs: 1'b1
  };

  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  blink_on;

  region_t              rg;
  logic [15:0]          x16, y16, b, lx, ly, row, col;
  logic [TADDR_W-1:0]   addr;
  logic [TILE_LOG2-1:0] px, py;
  logic                 on_edge, hit;
  pipe_t                in_p, s1, s2, s3;
  logic [11:0]          icon_q, color_nxt;

  assign blink_on = !blink_cnt[BLINK_LOG2-1];

  always_comb begin
    x16 = {6'b0, pixel_x};
    y16 = {6'b0, pixel_y};
    b   = '0;
    for (int k = 1; k < BOARDS; k++)
      if (x16 >= 16'(k * BRD_W)) b = 16'(k);
    lx  = x16 - b * BRDW16;
    ly  = y16 - TOP16;
    row = ly >> TILE_LOG2;
    col = lx >> TILE_LOG2;
    px  = lx[TILE_LOG2-1:0];
    py  = ly[TILE_LOG2-1:0];
    addr = TADDR_W'(b * GG16 + row * GRID16 + col);

    rg = R_OUT;
    if (y16 < TOP16)
      rg = R_TOP;
    else if (y16 >= Y1_16)
      rg = R_BOT;
    else if (x16 < XE16)
      rg = R_BOARD;

    on_edge = (px <= P_LO) || (px >= P_HI) ||
              (py <= P_LO) || (py >= P_HI);
    hit = cursor_en && blink_on && (rg == R_BOARD) &&
          (b == 16'(cursor_board)) &&
          (row == 16'(cursor_row)) &&
          (col == 16'(cursor_col)) && on_edge;

    in_p = '{
      region: rg, hit: hit, px: px, py: py,
      vid: vid_on, hs: hsync_in, vs: vsync_in
    };
  end

  always_comb begin
    color_nxt = 12'h000;
    if (s3.vid) begin
      unique case (s3.region)
        R_TOP: color_nxt = TOP_COLOR;
        R_BOT: color_nxt = BOTTOM_COLOR;
        R_OUT: color_nxt = 12'h000;
        R_BOARD: begin
          if (s3.hit)
            color_nxt = CURSOR_COLOR;
          else if (icon_q == KEY_COLOR)
            color_nxt = BG_COLOR;
          else
            color_nxt = icon_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt    <= '0;
      s1           <= RST_P;
      s2           <= RST_P;
      s3           <= RST_P;
      tile_address <= '0;
      icon_address <= '0;
      icon_q       <= '0;
      screen_color <= '0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      vid_on_out   <= 1'b0;
    end else begin
      if (frame_tick)
        blink_cnt <= blink_cnt + 1'b1;
      s1 <= in_p;
      s2 <= s1;
      s3 <= s2;
      // Addresses hold outside the boards so the memories see no churn.
      if (rg == R_BOARD)
        tile_address <= addr;
      if (s1.region == R_BOARD)
        icon_address <= {tile_data, s1.py, s1.px};
      icon_q       <= icon_data;
      screen_color <= color_nxt;
      hsync_out    <= s3.hs;
      vsync_out    <= s3.vs;
      vid_on_out   <= s3.vid;
    end
  end

endmodule
